// File: rtl/rns_mult_sched.sv
// Sequencing controller for one shared, pipelined RNS modular multiplier.
// Walks every (limb, slot) pair of a basis, tags in-flight products and writes results back.
module rns_mult_sched #(
    parameter int N_SLOTS   = 8,
    parameter int MAX_LIMBS = 4,
    parameter int MUL_LAT   = 3,
    parameter int COEF_W    = 32,
    parameter int SLOT_W    = $clog2(N_SLOTS),
    parameter int LIMB_W    = $clog2(MAX_LIMBS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LIMB_W-1:0] basis_len,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [SLOT_W-1:0] rd_slot,
    output logic [LIMB_W-1:0] rd_limb,
    input  logic [COEF_W-1:0] rd_a_data,
    input  logic [COEF_W-1:0] rd_b_data,
    output logic              mul_valid,
    output logic [COEF_W-1:0] mul_a,
    output logic [COEF_W-1:0] mul_b,
    output logic [LIMB_W-1:0] mul_limb,
    input  logic              mul_res_valid,
    input  logic [COEF_W-1:0] mul_res,
    output logic              wr_en,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [LIMB_W-1:0] wr_limb,
    output logic [COEF_W-1:0] wr_data
);

    // Handshake: rd_en is a one-way strobe (no ready); operands return exactly one
    // cycle later, and mul_res_valid must arrive exactly MUL_LAT cycles after mul_valid.
    localparam int DEPTH = 1 + MUL_LAT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [SLOT_W-1:0]             slot_q, slot_d;
    logic [LIMB_W-1:0]             limb_q, limb_d;
    logic [LIMB_W-1:0]             len_q, len_d;
    logic                          err_q, err_d;
    logic                          mul_valid_q, mul_valid_d;
    logic [LIMB_W-1:0]             mul_limb_q, mul_limb_d;
    logic [DEPTH-1:0]              tag_v_q, tag_v_d;
    logic [DEPTH-1:0][SLOT_W-1:0]  tag_slot_q, tag_slot_d;
    logic [DEPTH-1:0][LIMB_W-1:0]  tag_limb_q, tag_limb_d;

    logic start_ok;
    logic bad_len;
    logic last_slot;
    logic last_limb;
    logic issue_fire;
    logic tail_empty;
    logic res_mismatch;
    logic head_fire;

    assign start_ok   = (state_q == S_IDLE) && start;
    assign bad_len    = (basis_len == '0) || (basis_len > LIMB_W'(MAX_LIMBS));
    assign last_slot  = (slot_q == SLOT_W'(N_SLOTS - 1));
    assign last_limb  = (limb_q == len_q - LIMB_W'(1));
    assign issue_fire = (state_q == S_ISSUE) && !hold;
    // Only the head may still be valid: it retires this cycle, so the pipe is empty next.
    assign tail_empty = (tag_v_q[DEPTH-2:0] == '0);
    // Results arriving while idle (e.g. after a mid-run reset) are stale and ignored.
    assign res_mismatch = (state_q != S_IDLE) && (mul_res_valid != tag_v_q[DEPTH-1]);
    assign head_fire    = mul_res_valid && tag_v_q[DEPTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            limb_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            mul_valid_q <= 1'b0;
            mul_limb_q  <= '0;
            tag_v_q     <= '0;
            tag_slot_q  <= '0;
            tag_limb_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            limb_q      <= limb_d;
            len_q       <= len_d;
            err_q       <= err_d;
            mul_valid_q <= mul_valid_d;
            mul_limb_q  <= mul_limb_d;
            tag_v_q     <= tag_v_d;
            tag_slot_q  <= tag_slot_d;
            tag_limb_q  <= tag_limb_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = bad_len ? S_DONE : S_ISSUE;
            S_ISSUE: if (issue_fire && last_slot && last_limb) state_d = S_DRAIN;
            S_DRAIN: if (tail_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, error flag, operand stage and tag pipe
    always_comb begin
        slot_d      = slot_q;
        limb_d      = limb_q;
        len_d       = len_q;
        err_d       = err_q;
        mul_valid_d = rd_en;
        mul_limb_d  = limb_q;

        if (start_ok) begin
            slot_d = '0;
            limb_d = '0;
            len_d  = basis_len;
        end else if (issue_fire) begin
            if (last_slot) begin
                slot_d = '0;
                limb_d = last_limb ? '0 : limb_q + LIMB_W'(1);
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end

        if (start_ok) begin
            err_d = bad_len;
        end else if (res_mismatch) begin
            err_d = 1'b1;
        end

        tag_v_d    = {tag_v_q[DEPTH-2:0], rd_en};
        tag_slot_d = {tag_slot_q[DEPTH-2:0], slot_q};
        tag_limb_d = {tag_limb_q[DEPTH-2:0], limb_q};
    end

    // Output logic
    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        err       = err_q;
        rd_en     = issue_fire;
        rd_slot   = slot_q;
        rd_limb   = limb_q;
        mul_valid = mul_valid_q;
        mul_a     = rd_a_data;
        mul_b     = rd_b_data;
        mul_limb  = mul_limb_q;
        wr_en     = head_fire;
        wr_slot   = head_fire ? tag_slot_q[DEPTH-1] : '0;
        wr_limb   = head_fire ? tag_limb_q[DEPTH-1] : '0;
        wr_data   = head_fire ? mul_res : '0;
    end

endmodule

// File: doc/rns_mult_sched.md
Name: rns_mult_sched

Overview:
- Sequencing controller for a single shared, pipelined RNS modular multiplier.
- Walks every (limb, slot) pair of one basis (q, B or Ba), issues operand reads, and feeds operand pairs to the multiplier with the limb index as modulus select.
- Tags in-flight operations and issues result writes back to the coefficient RAM.
- Replaces the fully parallel per-slot/per-limb multiplier array with a time-multiplexed datapath.

Parameters:
- N_SLOTS, 8, polynomial slots per limb
- MAX_LIMBS, 4, largest basis length supported
- MUL_LAT, 3, cycles from mul_valid to mul_res_valid (>=1)
- COEF_W, 32, residue width
- SLOT_W, $clog2(N_SLOTS), slot index width
- LIMB_W, $clog2(MAX_LIMBS+1), limb index / count width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- basis_len  in  LIMB_W  limbs to process; sampled with start
- hold  in  1  pause new issues; in-flight ops continue
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag; cleared by the next accepted start
- rd_en  out  1  operand RAM read strobe
- rd_slot  out  SLOT_W  read slot index
- rd_limb  out  LIMB_W  read limb index
- rd_a_data  in  COEF_W  operand a; valid the cycle after rd_en
- rd_b_data  in  COEF_W  operand b; valid the cycle after rd_en
- mul_valid  out  1  operand pair valid to the multiplier
- mul_a  out  COEF_W  operand a
- mul_b  out  COEF_W  operand b
- mul_limb  out  LIMB_W  modulus select
- mul_res_valid  in  1  multiplier result valid
- mul_res  in  COEF_W  (a*b) mod modulus[mul_limb]
- wr_en  out  1  result write strobe
- wr_slot  out  SLOT_W  write slot index
- wr_limb  out  LIMB_W  write limb index
- wr_data  out  COEF_W  result

Behaviour:

Reset:
- All outputs are 0.
- State is IDLE, counters are 0, and the tag pipe is cleared.

Accepted start (start=1 in IDLE):
- basis_len in 1..MAX_LIMBS → ISSUE on the next cycle, busy=1, err cleared.
- basis_len 0 or >MAX_LIMBS → err=1, go to DONE, no reads are issued.
- start outside IDLE is ignored.

ISSUE:
- Each cycle with hold=0: rd_en=1 with the current (slot, limb), then advance.
- Iteration order: slot increments first, wrapping N_SLOTS-1→0 and incrementing limb.
- After the pair (N_SLOTS-1, basis_len-1) is issued → DRAIN.
- hold=1 → rd_en=0, counters frozen.
- Total issues = N_SLOTS*basis_len.

Operand stage:
- mul_valid = rd_en delayed 1 cycle.
- mul_limb = rd_limb delayed 1 cycle.
- mul_a/mul_b = rd_a_data/rd_b_data, combinational passthrough.

Tag pipe:
- Depth 1+MUL_LAT, carries valid/slot/limb from rd_en.
- Its output aligns with mul_res_valid.

Write stage:
- When mul_res_valid=1 and tag valid: wr_en=1, wr_slot/wr_limb from the tag, wr_data=mul_res, all combinational from the pipe head.
- Mismatch (mul_res_valid differs from tag valid) → err=1 and wr_en=0 that cycle; the operation continues.

DRAIN:
- Wait until the tag pipe is empty (write count = issue count), then go to DONE.

DONE:
- done=1 for one cycle, busy=0 in this cycle, then IDLE.

Latency:
- Start to first write: 2+MUL_LAT cycles.
- Start to done with no hold: N_SLOTS*basis_len + MUL_LAT + 2 cycles.

Reset mid-operation:
- Immediate abort to reset values; no done pulse.
- Later mul_res_valid arrivals are ignored without error until the next start.

hold during DRAIN or DONE: no effect.

Test Plan:
1. N_SLOTS=8, basis_len=3, a=slot+1, b=limb+2, ideal multiplier with MUL_LAT=3 → 24 writes in limb-major order, first write 5 cycles after start, done at cycle 29, err=0.
2. Same as 1 with hold high for cycles 4-7 → rd_en low for exactly those 4 cycles, write sequence unchanged, done 4 cycles later.
3. basis_len=0, then basis_len=5 → no rd_en, done on the cycle after start, err=1; next valid start clears err.
4. start pulsed again mid-ISSUE with basis_len=1 → ignored, original 24-write run completes unchanged.
5. rst_n asserted after 10 issues → outputs 0 immediately, no done; a fresh start with basis_len=1 gives 8 writes and done.
6. Inject a spurious mul_res_valid with the tag pipe empty during ISSUE → err=1, no wr_en that cycle, remaining writes still correct.
